product_bcd_converter: RTL

Sequential binary-to-BCD stage downstream of the 8-bit multiplier processor. It takes the 16-bit two's-complement product held in the A:B register pair when a multiply completes, converts its magnitude to decimal by iterative shift-and-add-3 (double-dabble), and presents a sign flag plus packed BCD digits to the display driver. One conversion runs at a time under a start/busy/valid handshake.

---
 rtl/product_bcd_pkg.sv | 25 ++
 rtl/bcd_digit_adjust.sv | 16 +
 rtl/product_bcd_converter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/product_bcd_pkg.sv
// Shared types and helpers for the product-to-BCD conversion stage.
package product_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DIGIT_W = 4;

    // Decimal digits needed to hold the largest magnitude, 2^(width-1).
    function automatic int required_digits(input int width);
        longint v;
        int     d;
        v = longint'(1) << (width - 1);
        d = 0;
        while (v > 0) begin
            v = v / 10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adjust
    import product_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= DIGIT_W'(5)) begin
            dout = din + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/product_bcd_converter.sv
// Converts the signed multiplier product to sign + packed BCD magnitude.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// SHIFT | one add-3/shift step per cycle, WIDTH steps
// DONE  | result just loaded, valid high, may restart on start
module product_bcd_converter
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH/2-1:0]       prod_hi,
    input  logic [WIDTH/2-1:0]       prod_lo,
    output logic                     busy,
    output logic                     valid,
    output logic                     neg,
    output logic [DIGIT_W*DIGITS-1:0] bcd
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int BCD_W  = DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    if (DIGITS < required_digits(WIDTH)) begin : g_digits_check
        $error("product_bcd_converter: DIGITS too small for WIDTH");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic               neg_next_q, neg_next_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;

    logic [BCD_W-1:0]       work_adj;
    logic [BCD_W+WIDTH-1:0] shifted;
    logic [WIDTH-1:0]       prod;
    logic                   capture;
    logic                   last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (work_q[DIGIT_W*g +: DIGIT_W]),
            .dout (work_adj[DIGIT_W*g +: DIGIT_W])
        );
    end

    assign prod       = {prod_hi, prod_lo};
    assign capture    = start && (state_q == IDLE || state_q == DONE);
    assign last_shift = (state_q == SHIFT) && (cnt_q == LAST_SHIFT);
    assign shifted    = {work_adj[BCD_W-2:0], mag_q, 1'b0};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_SHIFT) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state_q != IDLE);
        valid = (state_q == DONE);
    end

    // Datapath next values
    always_comb begin
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        work_d     = work_q;
        neg_next_d = neg_next_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        if (capture) begin
            // Two's-complement negate keeps 0x8000 as magnitude 32768.
            neg_next_d = prod[WIDTH-1];
            mag_d      = prod[WIDTH-1] ? (~prod + WIDTH'(1)) : prod;
            work_d     = '0;
            cnt_d      = '0;
        end else if (state_q == SHIFT) begin
            work_d = shifted[BCD_W+WIDTH-1:WIDTH];
            mag_d  = shifted[WIDTH-1:0];
            cnt_d  = cnt_q + CNT_W'(1);
        end
        // Result lands on the same edge that enters DONE.
        if (last_shift) begin
            bcd_d = shifted[BCD_W+WIDTH-1:WIDTH];
            neg_d = neg_next_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mag_q      <= '0;
            work_q     <= '0;
            neg_next_q <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            work_q     <= work_d;
            neg_next_q <= neg_next_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
        end
    end

    assign bcd = bcd_q;
    assign neg = neg_q;

endmodule
